mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter and sequencer for the single-port `memory` block. It accepts independent read/write commands from two clients and grants one at a time, round-robin. It drives the memory's `addr`/`wr_en`/`rd_en`/`wr_data` pins and returns read data to the granted client with a valid pulse. It sits between the client logic and `memory`, and is the only driver of the memory's command pins.

## Interface
Parameters:
- `ADDR_WIDTH`, default 6: memory address width; depth is 2**ADDR_WIDTH.
- `DATA_WIDTH`, default 8: memory word width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0` / `req1`  in  1  request from client 0 / 1. Held high until the matching `gnt` pulse.
- `we0` / `we1`  in  1  command type: 1 = write, 0 = read. Stable while `req` is high.
- `addr0` / `addr1`  in  ADDR_WIDTH  command address. Stable while `req` is high.
- `wdata0` / `wdata1`  in  DATA_WIDTH  write data. Stable while `req` is high.
- `gnt0` / `gnt1`  out  1  one-cycle pulse: this client's command is being issued.
- `rvalid0` / `rvalid1`  out  1  one-cycle pulse: `rdata` holds this client's read result.
- `rdata0` / `rdata1`  out  DATA_WIDTH  registered read result; holds its value until the next read for that client.
- `mem_addr`  out  ADDR_WIDTH  to `memory.addr`.
- `mem_wr_en`  out  1  to `memory.wr_en`.
- `mem_rd_en`  out  1  to `memory.rd_en`.
- `mem_wr_data`  out  DATA_WIDTH  to `memory.wr_data`.
- `mem_rd_data`  in  DATA_WIDTH  from `memory.rd_data`. The memory registers it on the edge that samples `rd_en` high.

## Operation
- **FSM states:** IDLE, CMD, RD_WAIT.
- **IDLE:**
  - No request: stay in IDLE.
  - Otherwise select a winner, go to CMD, and latch the winner index plus its `we` value.
- **CMD:**
  - Memory command outputs carry the winner's address and data.
  - Exactly one of `mem_wr_en` / `mem_rd_en` is high.
  - `gnt` for the winner is high.
  - Next state is RD_WAIT for a read, IDLE for a write.
- **RD_WAIT:** `mem_rd_data` is valid. Capture it into the winner's `rdata`, pulse its `rvalid`, and go to IDLE.
- **Winner selection:**
  - One requester: it wins.
  - Both requesting: the port not granted most recently wins.
  - The last-grant pointer updates on every grant.
  - After reset the pointer favours port 0.
- **Output registering:** all outputs are registered.
  - `mem_wr_en`, `mem_rd_en`, `gnt*` and `rvalid*` are low outside the states listed above.
  - `mem_addr` / `mem_wr_data` hold their last values.
- **Invariant:** `mem_wr_en` and `mem_rd_en` are never high together, and never high for two consecutive cycles.

## Timing
- **Write:** `req` sampled at edge k (state IDLE). `gnt` and `mem_wr_en` are high during cycle k→k+1. The next request is sampled at edge k+2. Throughput is one write per 2 cycles.
- **Read:**
  - `req` sampled at edge k. `gnt` and `mem_rd_en` are high during cycle k→k+1.
  - The memory returns data after edge k+1.
  - `rdata`/`rvalid` update at edge k+2; `rvalid` is high for cycle k+2→k+3.
  - The next request is sampled at edge k+3.
- **Requests in non-IDLE states:** not sampled; they wait. The losing requester keeps `req` high and is served in the next IDLE.
- **Requester deasserts `req` before `gnt`:** protocol violation, undefined. The bench must not do it.
- **Reset:** asynchronous.
  - State goes to IDLE; pointer favours port 0.
  - All `gnt`, `rvalid`, `mem_wr_en`, `mem_rd_en` = 0.
  - `mem_addr`, `mem_wr_data`, `rdata0`, `rdata1` = 0.
  - A read in flight at reset is dropped: no `rvalid` after reset release.

## Configuration
- Macro: `MEM_ARB_ROUND_ROBIN_EN`.
- **Defined:** round-robin selection as described in Operation.
- **Undefined:** fixed priority, port 0 always wins when both request. The last-grant pointer is not implemented. Port 1 can starve, which is the intended behaviour.

## Test plan
- **Reset values:** assert `rst` mid-read (in RD_WAIT) → all outputs 0 immediately; no `rvalid0` after release.
- **Single write then read:** client 0 writes 0xA5 to addr 0x12, then reads 0x12.
  - `gnt0` is a 1-cycle pulse, with `mem_wr_en`=1, `mem_addr`=0x12, `mem_wr_data`=0xA5.
  - `rvalid0` asserts 2 cycles after `gnt0` with `rdata0`=0xA5.
- **Simultaneous requests (RR on):** both clients hold `req` continuously with reads of 0x01 / 0x02.
  - Grant order is 0,1,0,1.
  - Each `rvalid` carries its own address's data.
  - `mem_rd_en` is never high on adjacent cycles.
- **Fixed priority (macro undefined):** same stimulus → `gnt0` on every grant; `gnt1` only after `req0` drops.
- **Back-to-back writes:** client 1 writes 0x00..0x3F with data = addr ^ 0xFF → one write per 2 cycles; readback of all 64 locations matches.
- **Mixed traffic:** client 0 writes addr 0x05 = 0x3C while client 1 reads 0x05 in the same cycle (RR, pointer at reset).
  - Write is granted first.
  - `rdata1` = 0x3C.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles every signal between the two memory clients, the arbiter and the
//   single-port memory. clk and rst are not part of the bundle.
//
//   Client side:  req0/1, we0/1, addr0/1, wdata0/1   (client  -> arbiter)
//                 gnt0/1, rvalid0/1, rdata0/1        (arbiter -> client)
//   Memory side:  mem_addr, mem_wr_en, mem_rd_en,
//                 mem_wr_data                        (arbiter -> memory)
//                 mem_rd_data                        (memory  -> arbiter)
//
//   Modports:
//     master - the arbiter. It owns the memory command pins.
//     slave  - the environment: the clients plus the memory.
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  rvalid0;
    logic                  rvalid1;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wr_en;
    logic                  mem_rd_en;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    modport master (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  mem_rd_data,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output mem_addr, mem_wr_en, mem_rd_en, mem_wr_data
    );

    modport slave (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output mem_rd_data,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  mem_addr, mem_wr_en, mem_rd_en, mem_wr_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Two-client arbiter and sequencer for a single-port memory. The arbiter
//   grants one read or write command at a time. It drives the memory command
//   pins and returns read data to the granted client with a one-cycle valid
//   pulse. Every output is registered.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous, active-high reset
//     bus  - mem_arbiter_if.master (client handshakes and memory pins)
//
//   Sequence: IDLE -> CMD -> IDLE              for a write (2 cycles)
//             IDLE -> CMD -> RD_WAIT -> IDLE   for a read  (3 cycles)
//
//   Build option:
//     MEM_ARB_ROUND_ROBIN_EN defined   - a contested grant goes to the port
//                                        that was not granted most recently.
//     MEM_ARB_ROUND_ROBIN_EN undefined - fixed priority: port 0 always wins
//                                        a contested grant (port 1 may starve).
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CMD     = 2'd1,
        S_RD_WAIT = 2'd2
    } state_t;

    state_t                r_state,       w_state;
    logic                  r_win,         w_win;      // granted port index
    logic                  r_we,          w_we;       // granted command is a write
    logic                  r_gnt0,        w_gnt0;
    logic                  r_gnt1,        w_gnt1;
    logic                  r_rvalid0,     w_rvalid0;
    logic                  r_rvalid1,     w_rvalid1;
    logic [DATA_WIDTH-1:0] r_rdata0,      w_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1,      w_rdata1;
    logic [ADDR_WIDTH-1:0] r_mem_addr,    w_mem_addr;
    logic                  r_mem_wr_en,   w_mem_wr_en;
    logic                  r_mem_rd_en,   w_mem_rd_en;
    logic [DATA_WIDTH-1:0] r_mem_wr_data, w_mem_wr_data;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                  r_last_gnt,    w_last_gnt;
`endif

    logic w_any_req;
    logic w_pick;      // port that wins if a grant is issued this cycle

    assign w_any_req = bus.req0 | bus.req1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // A contested grant goes to the port that was not granted last time.
    // An uncontested grant goes to whichever port is requesting.
    assign w_pick = (bus.req0 & bus.req1) ? ~r_last_gnt : ~bus.req0;
`else
    // Port 1 wins only when port 0 is not requesting.
    assign w_pick = ~bus.req0;
`endif

    // Next-state and next-output logic. The outputs are registered, so the
    // values computed in IDLE appear while the FSM sits in CMD. The values
    // computed in RD_WAIT appear in the cycle after RD_WAIT.
    always_comb begin
        // NOTE: every signal gets a default before the case, so that no path
        // leaves one unassigned and no latch is inferred.
        w_state       = r_state;
        w_win         = r_win;
        w_we          = r_we;
        w_gnt0        = 1'b0;
        w_gnt1        = 1'b0;
        w_rvalid0     = 1'b0;
        w_rvalid1     = 1'b0;
        w_mem_wr_en   = 1'b0;
        w_mem_rd_en   = 1'b0;
        w_mem_addr    = r_mem_addr;
        w_mem_wr_data = r_mem_wr_data;
        w_rdata0      = r_rdata0;
        w_rdata1      = r_rdata1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        w_last_gnt    = r_last_gnt;
`endif

        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state       = S_CMD;
                    w_win         = w_pick;
                    w_we          = w_pick ? bus.we1 : bus.we0;
                    w_gnt0        = ~w_pick;
                    w_gnt1        = w_pick;
                    w_mem_wr_en   = w_we;
                    w_mem_rd_en   = ~w_we;
                    w_mem_addr    = w_pick ? bus.addr1  : bus.addr0;
                    w_mem_wr_data = w_pick ? bus.wdata1 : bus.wdata0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    w_last_gnt    = w_pick;
`endif
                end
            end

            // The command is on the memory pins during this cycle. A write
            // is complete at the next edge. A read returns its data after
            // that edge.
            S_CMD: begin
                w_state = r_we ? S_IDLE : S_RD_WAIT;
            end

            // mem_rd_data is valid now. Route it to the client that was granted.
            S_RD_WAIT: begin
                w_state = S_IDLE;
                if (r_win) begin
                    w_rdata1  = bus.mem_rd_data;
                    w_rvalid1 = 1'b1;
                end else begin
                    w_rdata0  = bus.mem_rd_data;
                    w_rvalid0 = 1'b1;
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State and output registers. Reset also drops any read in flight,
    // so no rvalid can follow reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_win         <= 1'b0;
            r_we          <= 1'b0;
            r_gnt0        <= 1'b0;
            r_gnt1        <= 1'b0;
            r_rvalid0     <= 1'b0;
            r_rvalid1     <= 1'b0;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
            r_mem_addr    <= '0;
            r_mem_wr_en   <= 1'b0;
            r_mem_rd_en   <= 1'b0;
            r_mem_wr_data <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            // "Port 1 granted last" makes port 0 win the first contest.
            r_last_gnt    <= 1'b1;
`endif
        end else begin
            // NOTE: non-blocking assignments, so every register updates from
            // the values computed before this edge, whatever the statement order.
            r_state       <= w_state;
            r_win         <= w_win;
            r_we          <= w_we;
            r_gnt0        <= w_gnt0;
            r_gnt1        <= w_gnt1;
            r_rvalid0     <= w_rvalid0;
            r_rvalid1     <= w_rvalid1;
            r_rdata0      <= w_rdata0;
            r_rdata1      <= w_rdata1;
            r_mem_addr    <= w_mem_addr;
            r_mem_wr_en   <= w_mem_wr_en;
            r_mem_rd_en   <= w_mem_rd_en;
            r_mem_wr_data <= w_mem_wr_data;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_gnt    <= w_last_gnt;
`endif
        end
    end

    assign bus.gnt0        = r_gnt0;
    assign bus.gnt1        = r_gnt1;
    assign bus.rvalid0     = r_rvalid0;
    assign bus.rvalid1     = r_rvalid1;
    assign bus.rdata0      = r_rdata0;
    assign bus.rdata1      = r_rdata1;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wr_en   = r_mem_wr_en;
    assign bus.mem_rd_en   = r_mem_rd_en;
    assign bus.mem_wr_data = r_mem_wr_data;
endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Bench for mem_arbiter. Contents:
//   - a behavioural memory stub;
//   - two client drivers that work from command queues;
//   - a reference model that schedules the expected outputs, cycle by cycle,
//     from each grant;
//   - a compare process that runs on every falling edge outside reset;
//   - directed scenarios with hand-computed literal expectations.
//   Expected grant order follows MEM_ARB_ROUND_ROBIN_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int AW = 6;
    localparam int DW = 8;

    logic clk;
    logic rst;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory stub: read data registered on the rd_en edge
    logic [DW-1:0] mem_arr [2**AW];
    always @(posedge clk) begin
        if (bus.mem_wr_en) mem_arr[bus.mem_addr] <= bus.mem_wr_data;
        if (bus.mem_rd_en) bus.mem_rd_data <= mem_arr[bus.mem_addr];
    end

    // ---------------- client drivers
    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    cmd_t q0[$];
    cmd_t q1[$];
    cmd_t c0, c1;

    function automatic cmd_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_t c;
        c.we = we; c.addr = a; c.data = d;
        return c;
    endfunction

    initial begin
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        forever begin
            @(negedge clk);
            if (rst) bus.req0 = 1'b0;
            else begin
                if (bus.req0 && bus.gnt0) bus.req0 = 1'b0;
                if (!bus.req0 && q0.size() != 0) begin
                    c0 = q0.pop_front();
                    bus.we0 = c0.we; bus.addr0 = c0.addr; bus.wdata0 = c0.data;
                    bus.req0 = 1'b1;
                end
            end
        end
    end

    initial begin
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        forever begin
            @(negedge clk);
            if (rst) bus.req1 = 1'b0;
            else begin
                if (bus.req1 && bus.gnt1) bus.req1 = 1'b0;
                if (!bus.req1 && q1.size() != 0) begin
                    c1 = q1.pop_front();
                    bus.we1 = c1.we; bus.addr1 = c1.addr; bus.wdata1 = c1.data;
                    bus.req1 = 1'b1;
                end
            end
        end
    end

    // ---------------- reference model
    // A grant accepted at edge n puts its command outputs into the cycle
    // after n. A read also schedules its rvalid two cycles later. The next
    // request can be taken only at n+2 (write) or n+3 (read).
    typedef struct packed {
        logic          gnt0, gnt1, wr, rd, rv0, rv1, has_cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdat;
    } ev_t;

    ev_t           sched [8];
    ev_t           cur;
    logic [DW-1:0] ref_mem [2**AW];
    int            free_at = 0;
    logic          last_p  = 1'b1;
    logic          p, pwe;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;

    logic          e_gnt0, e_gnt1, e_rv0, e_rv1, e_wr, e_rd;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata0, e_rdata1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) sched[i] = '0;
            free_at = 0; last_p = 1'b1;
            e_gnt0 = 0; e_gnt1 = 0; e_rv0 = 0; e_rv1 = 0; e_wr = 0; e_rd = 0;
            e_addr = '0; e_wdata = '0; e_rdata0 = '0; e_rdata1 = '0;
        end else begin
            cyc++;
            if (cyc >= free_at && (bus.req0 || bus.req1)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                if (bus.req0 && bus.req1) p = !last_p;
                else                      p = bus.req1;
`else
                p = !bus.req0;
`endif
                last_p = p;
                pwe = p ? bus.we1   : bus.we0;
                pa  = p ? bus.addr1 : bus.addr0;
                pd  = p ? bus.wdata1 : bus.wdata0;
                sched[cyc % 8].gnt0    = !p;
                sched[cyc % 8].gnt1    = p;
                sched[cyc % 8].wr      = pwe;
                sched[cyc % 8].rd      = !pwe;
                sched[cyc % 8].has_cmd = 1'b1;
                sched[cyc % 8].addr    = pa;
                sched[cyc % 8].wdata   = pd;
                if (pwe) begin
                    ref_mem[pa] = pd;
                    free_at = cyc + 2;
                end else begin
                    if (p) sched[(cyc + 2) % 8].rv1 = 1'b1;
                    else   sched[(cyc + 2) % 8].rv0 = 1'b1;
                    sched[(cyc + 2) % 8].rdat = ref_mem[pa];
                    free_at = cyc + 3;
                end
            end
            cur = sched[cyc % 8];
            sched[cyc % 8] = '0;
            e_gnt0 = cur.gnt0; e_gnt1 = cur.gnt1;
            e_wr   = cur.wr;   e_rd   = cur.rd;
            e_rv0  = cur.rv0;  e_rv1  = cur.rv1;
            if (cur.has_cmd) begin e_addr = cur.addr; e_wdata = cur.wdata; end
            if (cur.rv0) e_rdata0 = cur.rdat;
            if (cur.rv1) e_rdata1 = cur.rdat;
        end
    end

    // ---------------- per-cycle compare and event logging
    logic prev_en;
    int   g_port[$];
    int   g_cyc[$];
    int   rv0_cnt = 0;
    int   rv1_cnt = 0;

    always @(negedge clk) begin
        if (rst) prev_en = 1'b0;
        else begin
            check("gnt0",        bus.gnt0,        e_gnt0);
            check("gnt1",        bus.gnt1,        e_gnt1);
            check("mem_wr_en",   bus.mem_wr_en,   e_wr);
            check("mem_rd_en",   bus.mem_rd_en,   e_rd);
            check("mem_addr",    bus.mem_addr,    e_addr);
            check("mem_wr_data", bus.mem_wr_data, e_wdata);
            check("rvalid0",     bus.rvalid0,     e_rv0);
            check("rvalid1",     bus.rvalid1,     e_rv1);
            check("rdata0",      bus.rdata0,      e_rdata0);
            check("rdata1",      bus.rdata1,      e_rdata1);
            check("en_exclusive", bus.mem_wr_en & bus.mem_rd_en, 1'b0);
            check("en_adjacent",  prev_en & (bus.mem_wr_en | bus.mem_rd_en), 1'b0);
            prev_en = bus.mem_wr_en | bus.mem_rd_en;
            if (bus.gnt0) begin g_port.push_back(0); g_cyc.push_back(cyc); end
            if (bus.gnt1) begin g_port.push_back(1); g_cyc.push_back(cyc); end
            if (bus.rvalid0) rv0_cnt++;
            if (bus.rvalid1) rv1_cnt++;
        end
    end

    // ---------------- helpers
    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || bus.req0 || bus.req1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain_timeout"}, 32'(n >= 2000), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_gnt(input int port, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = (port == 1) ? bus.gnt1 : bus.gnt0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt0"},    bus.gnt0,        0);
        check({tag, "_gnt1"},    bus.gnt1,        0);
        check({tag, "_rvalid0"}, bus.rvalid0,     0);
        check({tag, "_rvalid1"}, bus.rvalid1,     0);
        check({tag, "_wr_en"},   bus.mem_wr_en,   0);
        check({tag, "_rd_en"},   bus.mem_rd_en,   0);
        check({tag, "_addr"},    bus.mem_addr,    0);
        check({tag, "_wdata"},   bus.mem_wr_data, 0);
        check({tag, "_rdata0"},  bus.rdata0,      0);
        check({tag, "_rdata1"},  bus.rdata1,      0);
    endtask

    function automatic int port_at(input int i);
        return (i < g_port.size()) ? g_port[i] : 9;
    endfunction

    // ---------------- directed scenarios
    logic seen;
    int   bad_gaps;
    int   exp_order [4];

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single write then read by client 0.
        @(posedge clk); #1;
        q0.push_back(mk(1'b1, 6'h12, 8'hA5));
        q0.push_back(mk(1'b0, 6'h12, 8'h00));
        wait_gnt(0, seen);
        check("wr_gnt0_seen", seen, 1);
        check("wr_mem_wr_en", bus.mem_wr_en,   1);
        check("wr_mem_addr",  bus.mem_addr,    8'h12);
        check("wr_mem_data",  bus.mem_wr_data, 8'hA5);
        @(negedge clk);
        check("gnt0_one_cycle", bus.gnt0, 0);
        wait_gnt(0, seen);
        check("rd_gnt0_seen", seen, 1);
        check("rd_mem_rd_en", bus.mem_rd_en, 1);
        @(negedge clk);
        check("rvalid0_not_early", bus.rvalid0, 0);
        @(negedge clk);
        check("rvalid0_after_2", bus.rvalid0, 1);
        check("rdata0_a5",       bus.rdata0,  8'hA5);
        drain("single");

        // Preload 0x01/0x02 through client 1, so that port 1 is the last port granted.
        @(posedge clk); #1;
        q1.push_back(mk(1'b1, 6'h01, 8'h11));
        q1.push_back(mk(1'b1, 6'h02, 8'h22));
        drain("preload");

        // Both clients request at once, two reads each.
        g_port.delete(); g_cyc.delete();
        @(posedge clk); #1;
        q0.push_back(mk(1'b0, 6'h01, 8'h00));
        q0.push_back(mk(1'b0, 6'h01, 8'h00));
        q1.push_back(mk(1'b0, 6'h02, 8'h00));
        q1.push_back(mk(1'b0, 6'h02, 8'h00));
        drain("simul");
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 1, 1};
`endif
        check("simul_grants", g_port.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("simul_order%0d", i), port_at(i), exp_order[i]);
        check("simul_rdata0", bus.rdata0, 8'h11);
        check("simul_rdata1", bus.rdata1, 8'h22);

        // Back-to-back writes from client 1 to every address, then a full readback.
        g_port.delete(); g_cyc.delete();
        @(posedge clk); #1;
        for (int a = 0; a < 64; a++) q1.push_back(mk(1'b1, AW'(a), DW'(a) ^ 8'hFF));
        drain("b2b_wr");
        check("b2b_grants", g_cyc.size(), 64);
        bad_gaps = 0;
        for (int i = 1; i < g_cyc.size(); i++)
            if (g_cyc[i] - g_cyc[i-1] != 2) bad_gaps++;
        check("b2b_gap_not_2", bad_gaps, 0);
        rv1_cnt = 0;
        @(posedge clk); #1;
        for (int a = 0; a < 64; a++) q1.push_back(mk(1'b0, AW'(a), 8'h00));
        drain("b2b_rd");
        check("b2b_rvalid_count", rv1_cnt, 64);
        check("b2b_last_rdata1",  bus.rdata1, 8'hC0);

        // Mixed traffic after a reset: client 0 writes 0x05 while client 1 reads 0x05.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        g_port.delete(); g_cyc.delete();
        @(posedge clk); #1;
        q0.push_back(mk(1'b1, 6'h05, 8'h3C));
        q1.push_back(mk(1'b0, 6'h05, 8'h00));
        drain("mixed");
        check("mixed_first_is_write", port_at(0), 0);
        check("mixed_second",         port_at(1), 1);
        check("mixed_rdata1",         bus.rdata1, 8'h3C);

        // Assert reset while a read is in RD_WAIT.
        @(posedge clk); #1;
        q0.push_back(mk(1'b0, 6'h12, 8'h00));
        drain("pre_reset_rd");
        check("pre_reset_rdata0", bus.rdata0, 8'hED);
        @(posedge clk); #1;
        q0.push_back(mk(1'b0, 6'h12, 8'h00));
        wait_gnt(0, seen);
        check("inflight_gnt0_seen", seen, 1);
        @(negedge clk);
        rst = 1'b1;
        #1 check_all_zero("midread_reset");
        rv0_cnt = 0;
        @(negedge clk); rst = 1'b0;
        repeat (6) @(negedge clk);
        check("no_rvalid0_after_reset", rv0_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
